// File: rtl/dmc_pkg.sv
// Shared definitions for the data-memory controller: FSM state encoding,
// the address bit that selects the external bus, and the bus-error load value.
package dmc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LRD  = 2'd1,
    ST_EXT  = 2'd2,
    ST_DONE = 2'd3
  } dmc_state_e;

  localparam int          EXT_SEL_BIT  = 15;
  localparam int          EXT_ADDR_W   = 15;
  localparam logic [15:0] BUS_ERR_DATA = 16'hDEAD;

endpackage

// File: rtl/dmc_sram.sv
// Single-port synchronous RAM, 2^DEPTH_LOG2 x 16, write-first with a
// registered read port. Contents are never reset.
module dmc_sram #(
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] addr_i,
  input  logic [15:0]           wdata_i,
  output logic [15:0]           rdata_o
);

  logic [15:0] mem_q [0:(1<<DEPTH_LOG2)-1];
  logic [15:0] rdata_q;

  // Write-first: a write also presents the new word on the read register.
  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
        rdata_q       <= wdata_i;
      end else begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: local RAM below 0x8000, req/ack external bus above.
// Optional feature macro DMC_TIMEOUT_EN bounds the external wait with a bus error.
module data_mem_ctrl
  import dmc_pkg::*;
#(
  parameter int DEPTH_LOG2 = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [15:0]           mem_addr,
  input  logic [15:0]           mem_wdata,
  output logic [15:0]           mem_rdata,
  output logic                  mem_stall,
  output logic                  ext_req,
  output logic                  ext_we,
  output logic [EXT_ADDR_W-1:0] ext_addr,
  output logic [15:0]           ext_wdata,
  input  logic                  ext_ack,
  input  logic [15:0]           ext_rdata,
  output logic                  err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  dmc_state_e            state_q;
  logic [15:0]           mem_rdata_q;
  logic                  ext_req_q;
  logic                  ext_we_q;
  logic [EXT_ADDR_W-1:0] ext_addr_q;
  logic [15:0]           ext_wdata_q;
  logic                  err_q;
  logic [CNT_W-1:0]      cnt_q;

  logic        req_s;
  logic        ext_sel_s;
  logic        idle_s;
  logic        ram_en_s;
  logic        ram_we_s;
  logic        tmo_s;
  logic [15:0] ram_rdata_s;

  assign req_s     = mem_rd | mem_wr;
  assign ext_sel_s = mem_addr[EXT_SEL_BIT];
  assign idle_s    = (state_q == ST_IDLE);
  assign ram_en_s  = idle_s & req_s & ~ext_sel_s;
  assign ram_we_s  = ram_en_s & mem_wr;

`ifdef DMC_TIMEOUT_EN
  assign tmo_s = (cnt_q == CNT_W'(TIMEOUT - 1));
`else
  assign tmo_s = 1'b0;
`endif

  dmc_sram #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_sram (
    .clk     (clk),
    .en_i    (ram_en_s),
    .we_i    (ram_we_s),
    .addr_i  (mem_addr[DEPTH_LOG2-1:0]),
    .wdata_i (mem_wdata),
    .rdata_o (ram_rdata_s)
  );

  // Stall: local loads and any external access in IDLE, and every EXT cycle.
  always_comb begin
    mem_stall = 1'b0;
    case (state_q)
      ST_IDLE: mem_stall = req_s & (ext_sel_s | ~mem_wr);
      ST_EXT:  mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Controller FSM with its registered outputs and the EXT wait counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_rdata_q <= 16'h0000;
      ext_req_q   <= 1'b0;
      ext_we_q    <= 1'b0;
      ext_addr_q  <= '0;
      ext_wdata_q <= 16'h0000;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_s && ext_sel_s) begin
            state_q     <= ST_EXT;
            ext_req_q   <= 1'b1;
            ext_we_q    <= mem_wr;
            ext_addr_q  <= mem_addr[EXT_ADDR_W-1:0];
            ext_wdata_q <= mem_wdata;
            cnt_q       <= '0;
          end else if (req_s && !mem_wr) begin
            state_q <= ST_LRD;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_LRD: begin
          mem_rdata_q <= ram_rdata_s;
          state_q     <= ST_IDLE;
        end
        ST_EXT: begin
          if (ext_ack) begin
            ext_req_q <= 1'b0;
            if (!ext_we_q) begin
              mem_rdata_q <= ext_rdata;
            end
            state_q <= ST_DONE;
          end else if (tmo_s) begin
            ext_req_q <= 1'b0;
            if (!ext_we_q) begin
              mem_rdata_q <= BUS_ERR_DATA;
            end
            err_q   <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // In LRD the RAM read register is itself the load data; afterwards the copy holds it.
  assign mem_rdata = (state_q == ST_LRD) ? ram_rdata_s : mem_rdata_q;
  assign ext_req   = ext_req_q;
  assign ext_we    = ext_we_q;
  assign ext_addr  = ext_addr_q;
  assign ext_wdata = ext_wdata_q;
  assign err       = err_q;

endmodule
